uart_rx_multi: RTL and testbench

Parametrised UART receiver for the SHA-256 processor's host link, and the successor to the fixed 8N1 receiver. It adds configurable frame format, 3-sample majority voting and false-start rejection. It also adds parity, framing and break detection, plus a small first-word-fall-through (FWFT) receive FIFO with a valid/ready output. It sits between the pad-level `rx` line and the command/message loader.

---
 rtl/uart_rx_multi.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_multi.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_multi.sv
// Parametrised UART receiver: majority-voted sampling, parity/framing/break
// detection and a first-word-fall-through receive FIFO with valid/ready output.
module uart_rx_multi #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                rx,
   output logic [DATA_BITS-1:0]                rx_data,
   output logic                                rx_parity_err,
   output logic                                rx_frame_err,
   output logic                                rx_valid,
   input  logic                                rx_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
   output logic                                overrun,
   output logic                                break_det
);

   localparam int unsigned H  = CLKS_PER_BIT / 2;
   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned BW = $clog2(DATA_BITS + 1);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned NW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned EW = DATA_BITS + 2;

   localparam logic [CW-1:0] CNT_S0    = CW'(H - 1);
   localparam logic [CW-1:0] CNT_S1    = CW'(H);
   localparam logic [CW-1:0] CNT_DEC   = CW'(H + 1);
   localparam logic [CW-1:0] CNT_END   = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
   localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
   localparam logic [NW-1:0] FULL      = NW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BRKWAIT
   } state_t;

   state_t                state;
   logic                  rx_meta;
   logic                  rxs;
   logic [CW-1:0]         baud_cnt;
   logic                  samp0;
   logic                  samp1;
   logic [DATA_BITS-1:0]  shreg;
   logic [BW-1:0]         bit_idx;
   logic                  par_bit;
   logic                  par_err;
   logic                  stop_idx;
   logic                  ferr;

   logic                  maj;
   logic                  at_dec;
   logic                  at_end;
   logic                  brk_cond;
   logic                  fe_now;
   logic                  push;
   logic                  pop;
   logic                  wr_en;
   logic [EW-1:0]         entry;

   logic [EW-1:0]         mem [FIFO_DEPTH];
   logic [EW-1:0]         head;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   always_comb begin
      maj      = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);
      at_dec   = (baud_cnt == CNT_DEC);
      at_end   = (baud_cnt == CNT_END);
      brk_cond = (shreg == '0) && !par_bit && !maj;
      // Later stop bits accumulate onto the error already seen on earlier ones.
      fe_now   = (stop_idx & ferr) | ~maj;
      push     = (state == S_STOP) && at_dec && (stop_idx == LAST_STOP)
                 && !((stop_idx == 1'b0) && brk_cond);
      pop      = rx_valid && rx_ready;
      wr_en    = push && ((fifo_count != FULL) || pop);
      entry    = {par_err, fe_now, shreg};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         baud_cnt  <= '0;
         samp0     <= 1'b1;
         samp1     <= 1'b1;
         shreg     <= '0;
         bit_idx   <= '0;
         par_bit   <= 1'b0;
         par_err   <= 1'b0;
         stop_idx  <= 1'b0;
         ferr      <= 1'b0;
         break_det <= 1'b0;
      end else begin
         break_det <= 1'b0;
         baud_cnt  <= at_end ? '0 : baud_cnt + CW'(1);
         if (baud_cnt == CNT_S0) samp0 <= rxs;
         if (baud_cnt == CNT_S1) samp1 <= rxs;

         case (state)
            S_IDLE: begin
               baud_cnt <= '0;
               par_bit  <= 1'b0;
               par_err  <= 1'b0;
               ferr     <= 1'b0;
               stop_idx <= 1'b0;
               if (!rxs) state <= S_START;
            end
            S_START: begin
               if (at_dec && maj) begin
                  state <= S_IDLE;
               end else if (at_end) begin
                  state   <= S_DATA;
                  bit_idx <= '0;
               end
            end
            S_DATA: begin
               if (at_dec) shreg <= {maj, shreg[DATA_BITS-1:1]};
               if (at_end) begin
                  if (bit_idx == LAST_BIT) begin
                     state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                     stop_idx <= 1'b0;
                  end else begin
                     bit_idx <= bit_idx + BW'(1);
                  end
               end
            end
            S_PARITY: begin
               if (at_dec) begin
                  par_bit <= maj;
                  par_err <= (PARITY == 1) ? ~(^shreg ^ maj) : (^shreg ^ maj);
               end
               if (at_end) begin
                  state    <= S_STOP;
                  stop_idx <= 1'b0;
               end
            end
            S_STOP: begin
               if (at_dec) begin
                  if ((stop_idx == 1'b0) && brk_cond) begin
                     break_det <= 1'b1;
                     state     <= S_BRKWAIT;
                  end else if (stop_idx == LAST_STOP) begin
                     // Leave mid-bit so a back-to-back start edge is not missed.
                     state <= S_IDLE;
                  end else begin
                     ferr <= fe_now;
                  end
               end else if (at_end) begin
                  stop_idx <= 1'b1;
               end
            end
            S_BRKWAIT: begin
               baud_cnt <= '0;
               if (rxs) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // When full, a same-cycle pop frees exactly the slot being written.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= entry;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overrun    <= 1'b0;
      end else begin
         overrun <= push && !wr_en;
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (pop)   rd_ptr <= rd_ptr + PW'(1);
         case ({wr_en, pop})
            2'b10:   fifo_count <= fifo_count + NW'(1);
            2'b01:   fifo_count <= fifo_count - NW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_comb begin
      head          = mem[rd_ptr];
      rx_valid      = (fifo_count != '0);
      rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
      rx_frame_err  = rx_valid ? head[DATA_BITS]     : 1'b0;
      rx_parity_err = rx_valid ? head[DATA_BITS+1]   : 1'b0;
   end

endmodule

// File: tb/tb_uart_rx_multi.sv
// Scoreboard bench for uart_rx_multi: three instances (8N1, 7E1, 8N2) on one clock.
module tb_uart_rx_multi;

   localparam int CPB     = 16;
   // rx pin -> rxs (2) + IDLE detect (1) + START entry, then push-cycle offset, then register.
   localparam int LAT_8N1 = 3 + 1 + (10 - 1) * CPB + CPB / 2 + 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  rx_line;
   logic [2:0]  rdy;
   logic [7:0]  d0, d2;
   logic [6:0]  d1;
   logic [2:0]  pe, fe, vld, ovr, brk;
   logic [2:0]  cnt [3];
   logic [10:0] head [3];

   int n_total = 0;
   int n_pass  = 0;
   int ovr_seen [3] = '{0, 0, 0};
   int brk_seen [3] = '{0, 0, 0};
   int exp_cnt  [3] = '{0, 0, 0};
   int exp_ovr  [3] = '{0, 0, 0};
   logic [10:0] q0 [$];
   logic [10:0] q1 [$];
   logic [10:0] q2 [$];

   always #5 clk = ~clk;

   uart_rx_multi #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
      .clk(clk), .rst(rst), .rx(rx_line[0]), .rx_data(d0), .rx_parity_err(pe[0]),
      .rx_frame_err(fe[0]), .rx_valid(vld[0]), .rx_ready(rdy[0]), .fifo_count(cnt[0]),
      .overrun(ovr[0]), .break_det(brk[0]));

   uart_rx_multi #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
      .clk(clk), .rst(rst), .rx(rx_line[1]), .rx_data(d1), .rx_parity_err(pe[1]),
      .rx_frame_err(fe[1]), .rx_valid(vld[1]), .rx_ready(rdy[1]), .fifo_count(cnt[1]),
      .overrun(ovr[1]), .break_det(brk[1]));

   uart_rx_multi #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
      .clk(clk), .rst(rst), .rx(rx_line[2]), .rx_data(d2), .rx_parity_err(pe[2]),
      .rx_frame_err(fe[2]), .rx_valid(vld[2]), .rx_ready(rdy[2]), .fifo_count(cnt[2]),
      .overrun(ovr[2]), .break_det(brk[2]));

   always_comb begin
      head[0] = {pe[0], fe[0], 1'b0, d0};
      head[1] = {pe[1], fe[1], 2'b00, d1};
      head[2] = {pe[2], fe[2], 1'b0, d2};
   end

   // Counts high cycles, so a pulse wider than one cycle shows up as extra.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         ovr_seen[i] += int'(ovr[i]);
         brk_seen[i] += int'(brk[i]);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic idle(input int nbits);
      repeat (nbits * CPB) @(negedge clk);
   endtask

   task automatic send_bits(input int idx, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         rx_line[idx] = bits[i];
         repeat (CPB) @(negedge clk);
      end
      rx_line[idx] = 1'b1;
   endtask

   task automatic model_push(input int idx, input logic [10:0] e);
      if (exp_cnt[idx] < 4) begin
         case (idx)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
         endcase
         exp_cnt[idx]++;
      end else begin
         exp_ovr[idx]++;
      end
   endtask

   task automatic send_frame(input int idx, input logic [7:0] data, input logic pbit, input logic s2);
      logic [15:0] bits;
      logic [10:0] e;
      int n;
      case (idx)
         0: begin
            bits = {6'b0, 1'b1, data, 1'b0};
            n = 10;
            e = {3'b000, data};
         end
         1: begin
            bits = {6'b0, 1'b1, pbit, data[6:0], 1'b0};
            n = 10;
            e = {(^data[6:0]) ^ pbit, 1'b0, 2'b00, data[6:0]};
         end
         default: begin
            bits = {5'b0, s2, 1'b1, data, 1'b0};
            n = 11;
            e = {1'b0, ~s2, 1'b0, data};
         end
      endcase
      model_push(idx, e);
      send_bits(idx, bits, n);
   endtask

   task automatic timed_frame(input logic [7:0] data, input string tag);
      fork
         send_frame(0, data, 1'b0, 1'b1);
         begin
            int n;
            logic [2:0] c;
            n = 0;
            c = cnt[0];
            do begin
               @(negedge clk);
               n++;
            end while (cnt[0] == c && n < 400);
            check(tag, n, LAT_8N1);
         end
      join
   endtask

   task automatic pop_check(input int idx, input string tag);
      logic [10:0] e;
      int qs;
      case (idx)
         0: qs = q0.size();
         1: qs = q1.size();
         default: qs = q2.size();
      endcase
      if (qs == 0) begin
         check({tag, "_vld"}, vld[idx], 1'b0);
      end else begin
         case (idx)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
         endcase
         check({tag, "_cnt"}, cnt[idx], exp_cnt[idx]);
         check({tag, "_vld"}, vld[idx], 1'b1);
         check({tag, "_head"}, head[idx], e);
         rdy[idx] = 1'b1;
         @(negedge clk);
         rdy[idx] = 1'b0;
         exp_cnt[idx]--;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [15:0] pb;
      int o0, b0;
      rst     = 1'b1;
      rx_line = '1;
      rdy     = '0;
      repeat (3) @(negedge clk);
      check("rst_vld", vld, 3'b000);
      check("rst_cnt", {cnt[0], cnt[1], cnt[2]}, 0);
      check("rst_pulse", {ovr, brk}, 0);
      check("rst_flags", {pe, fe}, 0);
      check("rst_data", {d0, d1, d2}, 0);
      rst = 1'b0;
      idle(2);

      // 8N1 back-to-back, with latency of the first push
      timed_frame(8'hA5, "lat_a5");
      send_frame(0, 8'h3C, 1'b0, 1'b1);
      idle(1);
      check("two_cnt", cnt[0], 2);
      pop_check(0, "a5");
      pop_check(0, "3c");
      pop_check(0, "8n1_empty");

      // 7E1 good and bad parity
      send_frame(1, 8'h55, 1'b0, 1'b1);
      send_frame(1, 8'h55, 1'b1, 1'b1);
      idle(1);
      pop_check(1, "par_ok");
      pop_check(1, "par_bad");
      pop_check(1, "par_empty");

      // short low glitch is rejected, receiver still in sync afterwards
      rx_line[0] = 1'b0;
      repeat (4) @(negedge clk);
      rx_line[0] = 1'b1;
      idle(3);
      check("glitch_cnt", cnt[0], 0);
      check("glitch_vld", vld[0], 1'b0);
      timed_frame(8'h5A, "lat_after_glitch");
      pop_check(0, "5a");

      // 2 stop bits, second one low
      send_frame(2, 8'h81, 1'b0, 1'b0);
      idle(1);
      pop_check(2, "stop2_err");
      send_frame(2, 8'h81, 1'b0, 1'b1);
      idle(1);
      pop_check(2, "stop2_ok");

      // overrun: 5 frames into a 4-deep FIFO
      o0 = ovr_seen[0];
      for (int v = 1; v <= 5; v++) send_frame(0, 8'(v), 1'b0, 1'b1);
      idle(2);
      check("ovr_pulses", ovr_seen[0] - o0, exp_ovr[0]);
      check("ovr_cnt", cnt[0], 4);
      for (int i = 0; i < 4; i++) pop_check(0, "ovr_pop");
      pop_check(0, "ovr_empty");

      // break: 12 bit times low
      b0 = brk_seen[0];
      rx_line[0] = 1'b0;
      repeat (12 * CPB) @(negedge clk);
      rx_line[0] = 1'b1;
      idle(2);
      check("brk_pulses", brk_seen[0] - b0, 1);
      check("brk_nopush", cnt[0], 0);
      send_frame(0, 8'h7E, 1'b0, 1'b1);
      idle(1);
      pop_check(0, "7e");
      pop_check(0, "brk_empty");

      // reset during data bit 4 with one entry already stored
      send_frame(0, 8'h11, 1'b0, 1'b1);
      idle(1);
      check("pre_rst_cnt", cnt[0], 1);
      pb = {7'b0, 8'hC3, 1'b0};
      send_bits(0, pb, 5);
      rx_line[0] = pb[5];
      repeat (CPB / 2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_mid_out", {d0, pe[0], fe[0], vld[0], ovr[0], brk[0]}, 0);
      check("rst_mid_cnt", cnt[0], 0);
      rx_line[0] = 1'b1;
      rst = 1'b0;
      q0.delete();
      q1.delete();
      q2.delete();
      exp_cnt = '{0, 0, 0};
      idle(2);
      send_frame(0, 8'hC3, 1'b0, 1'b1);
      idle(1);
      pop_check(0, "c3");
      pop_check(0, "c3_empty");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
